tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Upstream stage of the speaker tone generator. Plays a stored Simon colour sequence as timed notes.
- Drives the 32-bit `freq` bus that the tone generator turns into the speaker square wave, and the matching one-hot colour LEDs.
- The game FSM loads a sequence and length, pulses `start`, and waits for `done`.
- `freq` = 0 means silence.

Parameters:
- MAX_LEN, 16, maximum sequence entries (2 bits each).
- NOTE_CYC, 25_000_000, clock cycles a note sounds (0.5 s at 50 MHz); must be >= 1.
- GAP_CYC, 5_000_000, silent clock cycles after every note; must be >= 1.
- F_GREEN, 415, Hz for colour code 0.
- F_RED, 310, Hz for colour code 1.
- F_YELLOW, 252, Hz for colour code 2.
- F_BLUE, 209, Hz for colour code 3.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to play the loaded sequence.
- abort  in  1  stop playback immediately.
- seq  in  2*MAX_LEN  packed colour codes; entry i = seq[2i+1:2i], entry 0 plays first.
- len  in  $clog2(MAX_LEN+1)  number of entries to play.
- freq  out  32  frequency to the tone generator; 0 = silent.
- led  out  4  one-hot lit colour (bit n = colour code n); 0 when silent.
- idx  out  $clog2(MAX_LEN)  index of the entry currently playing or gapping.
- busy  out  1  high while playing.
- done  out  1  one-cycle pulse when a sequence completes normally.

Behaviour:
- Reset (async assert, sync release) forces:
  - state IDLE;
  - freq=0, led=0, idx=0, busy=0, done=0;
  - timer=0, latched seq/len cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, NOTE, GAP.
- IDLE:
  - done is the previous-cycle pulse only; otherwise 0.
  - start=1 with len>0: at that edge latch seq and len, clamping len>MAX_LEN to MAX_LEN. Then state=NOTE, idx=0, busy=1, freq=F[seq[1:0]], led=one-hot(seq[1:0]), timer=NOTE_CYC-1.
  - start=1 with len=0: stay IDLE, done=1 for exactly one cycle, busy stays 0.
- NOTE:
  - Timer decrements each cycle; freq and led are held.
  - At timer=0: state=GAP, freq=0, led=0, timer=GAP_CYC-1.
  - Each note is therefore exactly NOTE_CYC cycles.
- GAP:
  - Timer decrements each cycle. At timer=0:
    - if idx = latched_len-1: state=IDLE, busy=0, done=1 (one cycle), idx holds its value.
    - else: idx=idx+1, state=NOTE, freq/led loaded from the entry at the new idx, timer=NOTE_CYC-1.
- Total busy duration is len*(NOTE_CYC+GAP_CYC) cycles. The first note appears the cycle after the start edge.
- start while busy is ignored; the latched seq and len are unaffected.
- Changes to seq or len while busy have no effect.
- abort=1 in any state, sampled at an edge:
  - state=IDLE, freq=0, led=0, busy=0, idx=0, done=0.
  - abort has priority over start in the same cycle, so nothing starts.
- Reset asserted mid-playback: immediate silence, all outputs go to their reset values.
- Width rules:
  - freq is the zero-extended 32-bit parameter value.
  - The timer is 32 bits.
  - idx never exceeds MAX_LEN-1; no wrap-around.

Test Plan (NOTE_CYC=4, GAP_CYC=2, MAX_LEN=8):
1. Reset: reset_n=0 mid-NOTE with freq=415 -> freq=0, led=0, busy=0 asynchronously, before the next clk edge; state stays IDLE after release.
2. Normal play: seq codes {0,1,3}, len=3, start pulse ->
   - freq sequence 415×4, 0×2, 310×4, 0×2, 209×4, 0×2;
   - led 0001/0010/1000 during notes;
   - busy high 18 cycles, then done=1 for exactly one cycle.
3. len=0 start -> no freq activity, busy stays 0, done pulses the next cycle. len=9 -> plays exactly 8 notes (48 busy cycles).
4. Retrigger: start re-pulsed at cycle 5 with different seq/len -> original sequence plays unchanged, single done pulse at the end.
5. Abort: abort during the second note's cycle 2 -> freq=0, led=0, busy=0, idx=0 next cycle, no done. Then abort and start asserted together in IDLE -> stays IDLE.
6. Back-to-back: start asserted in the same cycle done=1 -> new sequence begins, first note appears the next cycle; freq count checks match len*(NOTE_CYC+GAP_CYC).

Source files
------------

// File: rtl/tone_sequencer.sv
// tone_sequencer
//   Plays a latched Simon colour sequence as timed notes for the speaker
//   tone generator. Each entry sounds for NOTE_CYC cycles, followed by
//   GAP_CYC silent cycles. All outputs are registered.
//
// Ports
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   start    one-cycle request to play seq/len (ignored while busy)
//   abort    return to idle and silence immediately (beats start)
//   seq      packed 2-bit colour codes, entry 0 in seq[1:0]
//   len      number of entries to play (clamped to MAX_LEN)
//   freq     tone frequency in Hz, 0 = silent
//   led      one-hot colour lamp, 0 when silent
//   idx      entry currently playing or gapping
//   busy     high while a sequence is playing
//   done     one-cycle pulse when a sequence completes normally
module tone_sequencer #(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned NOTE_CYC = 25_000_000,
  parameter int unsigned GAP_CYC  = 5_000_000,
  parameter int unsigned F_GREEN  = 415,
  parameter int unsigned F_RED    = 310,
  parameter int unsigned F_YELLOW = 252,
  parameter int unsigned F_BLUE   = 209,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  localparam int unsigned IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2*MAX_LEN-1:0] seq,
  input  logic [LEN_W-1:0]     len,
  output logic [31:0]          freq,
  output logic [3:0]           led,
  output logic [IDX_W-1:0]     idx,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          timer_q, timer_d;
  logic [2*MAX_LEN-1:0] seq_q, seq_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [31:0]          freq_q, freq_d;
  logic [3:0]           led_q, led_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [IDX_W-1:0]     next_idx;
  logic [1:0]           next_code;
  logic                 last_entry;

  function automatic logic [31:0] code_freq(input logic [1:0] code);
    case (code)
      2'd0:    code_freq = 32'(F_GREEN);
      2'd1:    code_freq = 32'(F_RED);
      2'd2:    code_freq = 32'(F_YELLOW);
      default: code_freq = 32'(F_BLUE);
    endcase
  endfunction

  function automatic logic [3:0] code_led(input logic [1:0] code);
    code_led = 4'b0001 << code;
  endfunction

  assign next_idx   = IDX_W'(idx_q + IDX_W'(1));
  assign next_code  = seq_q[2*next_idx +: 2];
  assign last_entry = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    seq_d   = seq_q;
    len_d   = len_q;
    idx_d   = idx_q;
    freq_d  = freq_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            seq_d   = seq;
            len_d   = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
            state_d = NOTE;
            idx_d   = '0;
            busy_d  = 1'b1;
            freq_d  = code_freq(seq[1:0]);
            led_d   = code_led(seq[1:0]);
            timer_d = 32'(NOTE_CYC - 1);
          end
        end
      end
      NOTE: begin
        if (timer_q == '0) begin
          state_d = GAP;
          freq_d  = '0;
          led_d   = '0;
          timer_d = 32'(GAP_CYC - 1);
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          if (last_entry) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = NOTE;
            idx_d   = next_idx;
            freq_d  = code_freq(next_code);
            led_d   = code_led(next_code);
            timer_d = 32'(NOTE_CYC - 1);
          end
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        freq_d  = '0;
        led_d   = '0;
      end
    endcase

    // Abort overrides whatever the state logic chose, including a start.
    if (abort) begin
      state_d = IDLE;
      timer_d = '0;
      idx_d   = '0;
      freq_d  = '0;
      led_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      seq_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      freq_q  <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      seq_q   <= seq_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      freq_q  <= freq_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign freq = freq_q;
  assign led  = led_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with NOTE_CYC=4, GAP_CYC=2, MAX_LEN=8.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] seq = '0;
  logic [3:0]  len = '0;
  logic [31:0] freq;
  logic [3:0]  led;
  logic [2:0]  idx;
  logic        busy;
  logic        done;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  tone_sequencer #(
    .MAX_LEN (8),
    .NOTE_CYC(4),
    .GAP_CYC (2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .abort  (abort),
    .seq    (seq),
    .len    (len),
    .freq   (freq),
    .led    (led),
    .idx    (idx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hz(input logic [1:0] code);
    case (code)
      2'd0:    hz = 32'd415;
      2'd1:    hz = 32'd310;
      2'd2:    hz = 32'd252;
      default: hz = 32'd209;
    endcase
  endfunction

  task automatic do_start(input logic [15:0] s, input logic [3:0] l);
    seq   = s;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called on the first note cycle; returns on the done cycle.
  // retrig >= 0 pulses start with a different sequence at that cycle.
  task automatic play_check(input string tag, input logic [15:0] s, input int n, input int retrig);
    int cyc;
    int busy_cnt;
    logic [1:0] code;
    cyc = 0;
    busy_cnt = 0;
    for (int k = 0; k < n; k++) begin
      code = s[2*k +: 2];
      for (int c = 0; c < 6; c++) begin
        if (c < 4) begin
          check({tag, "_freq"}, freq, hz(code));
          check({tag, "_led"}, {28'd0, led}, {28'd0, 4'b0001 << code});
        end else begin
          check({tag, "_gapfreq"}, freq, 32'd0);
          check({tag, "_gapled"}, {28'd0, led}, 32'd0);
        end
        check({tag, "_idx"}, {29'd0, idx}, k);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        if (busy) busy_cnt++;
        if (cyc == retrig) begin
          seq = 16'hAAAA;
          len = 4'd5;
          start = 1'b1;
        end else if (cyc == retrig + 1) begin
          start = 1'b0;
        end
        cyc++;
        tick();
      end
    end
    check({tag, "_busycnt"}, busy_cnt, n * 6);
    check({tag, "_endbusy"}, {31'd0, busy}, 32'd0);
    check({tag, "_enddone"}, {31'd0, done}, 32'd1);
    check({tag, "_endidx"}, {29'd0, idx}, n - 1);
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_freq", freq, 32'd0);
    check("rst_led", {28'd0, led}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_idx", {29'd0, idx}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // 1. Async reset in the middle of a note
    do_start(16'h0034, 4'd3);   // codes 0,1,3
    tick();
    check("mid_freq", freq, 32'd415);
    #2 reset_n = 1'b0;
    #1;
    check("arst_freq", freq, 32'd0);
    check("arst_led", {28'd0, led}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    #3 reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_freq", freq, 32'd0);

    // 2. Normal play {0,1,3}
    do_start(16'h0034, 4'd3);
    play_check("play3", 16'h0034, 3, -1);
    tick();
    check("play3_done_clr", {31'd0, done}, 32'd0);
    check("play3_idle_busy", {31'd0, busy}, 32'd0);

    // 3a. len=0
    do_start(16'h00FF, 4'd0);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_busy", {31'd0, busy}, 32'd0);
    check("len0_freq", freq, 32'd0);
    tick();
    check("len0_done_clr", {31'd0, done}, 32'd0);
    check("len0_busy2", {31'd0, busy}, 32'd0);

    // 3b. len=9 clamps to 8 entries: codes 3,2,1,0,0,1,2,3
    do_start(16'hE41B, 4'd9);
    play_check("clamp", 16'hE41B, 8, -1);
    tick();

    // 4. Retrigger while busy, codes 2,0
    do_start(16'h0002, 4'd2);
    play_check("retrig", 16'h0002, 2, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("retrig_done_clr", {31'd0, done}, 32'd0);
      check("retrig_idle", {31'd0, busy}, 32'd0);
    end

    // 5. Abort during second note's third cycle
    do_start(16'h0034, 4'd3);
    repeat (8) tick();
    check("ab_pre_freq", freq, 32'd310);
    check("ab_pre_idx", {29'd0, idx}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_freq", freq, 32'd0);
    check("ab_led", {28'd0, led}, 32'd0);
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_idx", {29'd0, idx}, 32'd0);
    check("ab_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("ab_nodone", {31'd0, done}, 32'd0);
    end
    abort = 1'b1;
    do_start(16'h0034, 4'd3);
    abort = 1'b0;
    check("ab_start_busy", {31'd0, busy}, 32'd0);
    check("ab_start_freq", freq, 32'd0);
    tick();
    check("ab_start_busy2", {31'd0, busy}, 32'd0);

    // 6. Back-to-back: restart on the done cycle
    do_start(16'h0001, 4'd1);   // code 1
    play_check("b2b_a", 16'h0001, 1, -1);
    do_start(16'h000E, 4'd2);   // codes 2,3
    play_check("b2b_b", 16'h000E, 2, -1);
    tick();
    check("b2b_done_clr", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
